bus_arbiter: RTL and testbench

Central arbiter for the shared system bus. Up to MASTERS bus masters (CPU at index 0, DMA controllers and other initiators above it) raise `bus_req`; the arbiter issues a one-hot `bus_grant` using round-robin priority. Between owners it always inserts one dead cycle so that tri-stated address, data and control drivers never overlap. It also contains the bus watchdog: it observes `rd_bus`/`wr_bus`/`fc_bus` and pulses `watchdog` when a transfer stalls, which aborts DMA transfers and forces the grant back.

---
 rtl/bus_arbiter_pkg.sv | 42 ++++
 rtl/bus_arbiter_if.sv | 29 ++
 rtl/bus_arbiter_watchdog.sv | 44 ++++
 rtl/bus_arbiter.sv | 134 +++++++++++++
 tb/tb_bus_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the system bus arbiter: default parameters, FSM states,
// strobe bundle and the round-robin pick helper.
package bus_arbiter_pkg;

  localparam int unsigned DEF_MASTERS         = 4;
  localparam int unsigned DEF_DEFAULT_MASTER  = 0;
  localparam int unsigned DEF_WATCHDOG_CYCLES = 255;
  localparam int unsigned MAX_MASTERS         = 8;
  localparam int unsigned MAX_IDX_W           = 3;

  typedef enum logic [1:0] {
    ST_GAP  = 2'd0,
    ST_PARK = 2'd1,
    ST_OWN  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic rd;
    logic wr;
    logic fc;
  } bus_strobe_t;

  // First set request searching upward from last+1, wrapping at 'masters'.
  function automatic int unsigned rr_pick(input logic [MAX_MASTERS-1:0] req,
                                          input int unsigned masters,
                                          input int unsigned last);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
      idx = (last + i) % masters;
      if ((i <= masters) && !found && req[idx[MAX_IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration-side view of the shared bus: requests, grant, owner and observed strobes.
interface bus_arbiter_if #(
  parameter int unsigned MASTERS = bus_arbiter_pkg::DEF_MASTERS
) ();

  localparam int unsigned IDX_W = $clog2(MASTERS);

  logic [MASTERS-1:0] bus_req;
  logic [MASTERS-1:0] bus_grant;
  logic [IDX_W-1:0]   owner;
  logic               owner_valid;
  logic               rd_bus;
  logic               wr_bus;
  logic               fc_bus;
  logic               watchdog;

  // Arbiter side: samples requests and strobes, drives grant and watchdog.
  modport master (
    input  bus_req, rd_bus, wr_bus, fc_bus,
    output bus_grant, owner, owner_valid, watchdog
  );

  // Requester / bus side.
  modport slave (
    output bus_req, rd_bus, wr_bus, fc_bus,
    input  bus_grant, owner, owner_valid, watchdog
  );

endinterface

// File: rtl/bus_arbiter_watchdog.sv
// Bus stall watchdog: counts cycles where exactly one strobe is active without
// function-complete and emits a one-cycle pulse after WATCHDOG_CYCLES of them.
module bus_arbiter_watchdog #(
  parameter int unsigned WATCHDOG_CYCLES = bus_arbiter_pkg::DEF_WATCHDOG_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  bus_arbiter_pkg::bus_strobe_t i_strobe,
  output logic                         o_watchdog
);

  import bus_arbiter_pkg::*;

  localparam int unsigned      CNT_W    = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WATCHDOG_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_watchdog;
  logic             w_stall;

  // rd and wr together is an invalid strobe pattern and is treated as idle.
  assign w_stall = (i_strobe.rd ^ i_strobe.wr) & ~i_strobe.fc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_watchdog <= 1'b0;
    end else if (!w_stall) begin
      r_cnt      <= '0;
      r_watchdog <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt      <= '0;
      r_watchdog <= 1'b1;
    end else begin
      if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_watchdog <= 1'b0;
    end
  end

  assign o_watchdog = r_watchdog;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter with one dead cycle between owners, parking on
// DEFAULT_MASTER when idle, and a watchdog that forces the grant back on stalls.
module bus_arbiter #(
  parameter int unsigned MASTERS         = bus_arbiter_pkg::DEF_MASTERS,
  parameter int unsigned DEFAULT_MASTER  = bus_arbiter_pkg::DEF_DEFAULT_MASTER,
  parameter int unsigned WATCHDOG_CYCLES = bus_arbiter_pkg::DEF_WATCHDOG_CYCLES
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.master bus
);

  import bus_arbiter_pkg::*;

  localparam int unsigned        IDX_W   = $clog2(MASTERS);
  localparam logic [IDX_W-1:0]   DEF_IDX = IDX_W'(DEFAULT_MASTER);
  localparam logic [IDX_W-1:0]   TOP_IDX = IDX_W'(MASTERS - 1);
  localparam logic [MASTERS-1:0] DEF_BIT = MASTERS'(1) << DEFAULT_MASTER;

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   w_last_nxt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_owner_nxt;
  logic [IDX_W-1:0]   w_owner_out_nxt;
  logic [IDX_W-1:0]   w_win;
  logic [MASTERS-1:0] r_grant;
  logic [MASTERS-1:0] w_grant_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               w_any_req;
  logic               w_other_req;
  logic               w_only_def;
  logic               w_owner_req;
  logic               w_xfer;
  logic               w_watchdog;
  bus_strobe_t        w_strobe;

  assign w_strobe = '{rd: bus.rd_bus, wr: bus.wr_bus, fc: bus.fc_bus};

  bus_arbiter_watchdog #(
    .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .i_strobe   (w_strobe),
    .o_watchdog (w_watchdog)
  );

  // Request qualifiers used by the FSM.
  assign w_win       = IDX_W'(rr_pick(MAX_MASTERS'(bus.bus_req), MASTERS, 32'(r_last)));
  assign w_any_req   = |bus.bus_req;
  assign w_only_def  = (bus.bus_req == DEF_BIT);
  assign w_other_req = |(bus.bus_req & ~DEF_BIT);
  assign w_owner_req = bus.bus_req[r_owner];
  assign w_xfer      = bus.rd_bus | bus.wr_bus;

  // State register together with the registered grant outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_GAP;
      r_last  <= TOP_IDX;
      r_owner <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_owner <= w_owner_out_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state: a watchdog pulse revokes from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_owner_nxt = r_owner;
    if (w_watchdog) begin
      w_state_nxt = ST_GAP;
    end else begin
      case (r_state)
        ST_GAP: begin
          if (w_any_req) begin
            w_state_nxt = ST_OWN;
            w_owner_nxt = w_win;
            w_last_nxt  = w_win;
          end else begin
            w_state_nxt = ST_PARK;
            w_owner_nxt = DEF_IDX;
          end
        end
        ST_PARK: begin
          // Parked master taking ownership is not a handover, so no gap.
          if (w_only_def) begin
            w_state_nxt = ST_OWN;
            w_owner_nxt = DEF_IDX;
            w_last_nxt  = DEF_IDX;
          end else if (w_other_req && !w_xfer) begin
            w_state_nxt = ST_GAP;
          end
        end
        ST_OWN: begin
          if (!w_owner_req) begin
            w_state_nxt = ST_GAP;
          end
        end
        default: begin
          w_state_nxt = ST_GAP;
        end
      endcase
    end
  end

  // Output decode of the next state, captured by the state register.
  always_comb begin
    w_grant_nxt     = '0;
    w_valid_nxt     = 1'b0;
    w_owner_out_nxt = '0;
    if (w_state_nxt != ST_GAP) begin
      w_grant_nxt     = MASTERS'(1) << w_owner_nxt;
      w_valid_nxt     = 1'b1;
      w_owner_out_nxt = w_owner_nxt;
    end
  end

  assign bus.bus_grant   = r_grant;
  assign bus.owner       = r_owner;
  assign bus.owner_valid = r_valid;
  assign bus.watchdog    = w_watchdog;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (4 masters, default 0, watchdog after 4 stalled cycles).
module tb_bus_arbiter;

  typedef struct {
    logic [3:0] grant;
    logic       wd;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bus_arbiter_if #(.MASTERS(4)) bus ();

  bus_arbiter #(
    .MASTERS         (4),
    .DEFAULT_MASTER  (0),
    .WATCHDOG_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_head();
    exp_t       e;
    logic [1:0] eo;
    e  = exp_q.pop_front();
    eo = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (e.grant[i]) eo = 2'(i);
    end
    n_assert++;
    assert (bus.bus_grant === e.grant) else begin
      n_fail++;
      $error("FAIL %s bus_grant observed=%b expected=%b", e.tag, bus.bus_grant, e.grant);
    end
    n_assert++;
    assert (bus.owner_valid === (|e.grant)) else begin
      n_fail++;
      $error("FAIL %s owner_valid observed=%b expected=%b", e.tag, bus.owner_valid, |e.grant);
    end
    n_assert++;
    assert (bus.owner === eo) else begin
      n_fail++;
      $error("FAIL %s owner observed=%0d expected=%0d", e.tag, bus.owner, eo);
    end
    n_assert++;
    assert (bus.watchdog === e.wd) else begin
      n_fail++;
      $error("FAIL %s watchdog observed=%b expected=%b", e.tag, bus.watchdog, e.wd);
    end
  endtask

  task automatic expect_now(input logic [3:0] eg, input logic ewd, input string tag);
    exp_q.push_back('{grant: eg, wd: ewd, tag: tag});
    check_head();
  endtask

  // Called near a falling edge: drive inputs, expect outputs after the next rising edge.
  task automatic step(input logic [3:0] req, input logic rd, input logic wr, input logic fc,
                      input logic [3:0] eg, input logic ewd, input string tag);
    bus.bus_req = req;
    bus.rd_bus  = rd;
    bus.wr_bus  = wr;
    bus.fc_bus  = fc;
    exp_q.push_back('{grant: eg, wd: ewd, tag: tag});
    @(posedge clk);
    #1;
    check_head();
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b0;
    bus.bus_req = 4'b0000;
    bus.rd_bus  = 1'b0;
    bus.wr_bus  = 1'b0;
    bus.fc_bus  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_now(4'b0000, 1'b0, "reset");
    rst = 1'b1;
    expect_now(4'b0000, 1'b0, "release_gap");

    // Idle after reset: one GAP cycle, then park on master 0.
    step(4'b0000, 0, 0, 0, 4'b0001, 0, "park0");
    step(4'b0000, 0, 0, 0, 4'b0001, 0, "park1");

    // Round robin over masters 1..3, each dropping after three granted cycles.
    step(4'b1110, 0, 0, 0, 4'b0000, 0, "rr_gap0");
    step(4'b1110, 0, 0, 0, 4'b0010, 0, "rr_m1a");
    step(4'b1110, 0, 0, 0, 4'b0010, 0, "rr_m1b");
    step(4'b1110, 0, 0, 0, 4'b0010, 0, "rr_m1c");
    step(4'b1100, 0, 0, 0, 4'b0000, 0, "rr_gap1");
    step(4'b1110, 0, 0, 0, 4'b0100, 0, "rr_m2a");
    step(4'b1110, 0, 0, 0, 4'b0100, 0, "rr_m2b");
    step(4'b1110, 0, 0, 0, 4'b0100, 0, "rr_m2c");
    step(4'b1010, 0, 0, 0, 4'b0000, 0, "rr_gap2");
    step(4'b1110, 0, 0, 0, 4'b1000, 0, "rr_m3a");
    step(4'b1110, 0, 0, 0, 4'b1000, 0, "rr_m3b");
    step(4'b1110, 0, 0, 0, 4'b1000, 0, "rr_m3c");
    step(4'b0110, 0, 0, 0, 4'b0000, 0, "rr_gap3");
    step(4'b1110, 0, 0, 0, 4'b0010, 0, "rr_wrap");
    step(4'b0000, 0, 0, 0, 4'b0000, 0, "rr_gap4");
    step(4'b0000, 0, 0, 0, 4'b0001, 0, "rr_park");

    // Preempting a parked bus: one dead cycle, grant on the second edge.
    step(4'b0100, 0, 0, 0, 4'b0000, 0, "pre_gap");
    step(4'b0100, 0, 0, 0, 4'b0100, 0, "pre_m2");
    step(4'b0000, 0, 0, 0, 4'b0000, 0, "pre_drop");
    step(4'b0000, 0, 0, 0, 4'b0001, 0, "pre_park");

    // Parked transfer in flight is not preempted (fc keeps the watchdog quiet).
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 1, 0, 1, 4'b0001, 0, "inflight_hold");
    end
    step(4'b0010, 0, 0, 0, 4'b0000, 0, "inflight_gap");
    step(4'b0010, 0, 0, 0, 4'b0010, 0, "inflight_m1");
    step(4'b0000, 0, 0, 0, 4'b0000, 0, "inflight_drop");
    step(4'b0000, 0, 0, 0, 4'b0001, 0, "inflight_park");

    // Watchdog on a stalled read by owner 1; master 0 wins afterwards.
    step(4'b0010, 0, 0, 0, 4'b0000, 0, "wd_gap");
    step(4'b0010, 0, 0, 0, 4'b0010, 0, "wd_own1");
    step(4'b0011, 1, 0, 0, 4'b0010, 0, "wd_stall1");
    step(4'b0011, 1, 0, 0, 4'b0010, 0, "wd_stall2");
    step(4'b0011, 1, 0, 0, 4'b0010, 0, "wd_stall3");
    step(4'b0011, 1, 0, 0, 4'b0010, 1, "wd_pulse");
    step(4'b0011, 0, 0, 0, 4'b0000, 0, "wd_revoke");
    step(4'b0011, 0, 0, 0, 4'b0001, 0, "wd_next_m0");
    step(4'b0000, 0, 0, 0, 4'b0000, 0, "wd_drop");
    step(4'b0000, 0, 0, 0, 4'b0001, 0, "wd_park");

    // fc on the fourth stalled cycle suppresses the pulse and restarts the count.
    step(4'b0000, 1, 0, 0, 4'b0001, 0, "fc_stall1");
    step(4'b0000, 1, 0, 0, 4'b0001, 0, "fc_stall2");
    step(4'b0000, 1, 0, 0, 4'b0001, 0, "fc_stall3");
    step(4'b0000, 1, 0, 1, 4'b0001, 0, "fc_wins");
    step(4'b0000, 1, 0, 0, 4'b0001, 0, "fc_restart1");
    step(4'b0000, 1, 0, 0, 4'b0001, 0, "fc_restart2");
    step(4'b0000, 1, 0, 0, 4'b0001, 0, "fc_restart3");
    step(4'b0000, 1, 0, 0, 4'b0001, 1, "fc_restart_pulse");
    step(4'b0000, 0, 0, 0, 4'b0000, 0, "fc_revoke");
    step(4'b0000, 0, 0, 0, 4'b0001, 0, "fc_park");

    // rd and wr together is never counted as a stall.
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1, 1, 0, 4'b0001, 0, "invalid_strobes");
    end

    // Asynchronous reset in the middle of an ownership.
    step(4'b0100, 0, 0, 0, 4'b0000, 0, "ar_gap");
    step(4'b0100, 0, 0, 0, 4'b0100, 0, "ar_own2");
    #2;
    rst = 1'b0;
    #1;
    expect_now(4'b0000, 1'b0, "async_reset");
    @(negedge clk);
    rst = 1'b1;
    step(4'b0100, 0, 0, 0, 4'b0100, 0, "ar_regrant");
    step(4'b0000, 0, 0, 0, 4'b0000, 0, "ar_drop");
    step(4'b0000, 0, 0, 0, 4'b0001, 0, "ar_park");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
